// File: rtl/arm_mc_pkg.sv
// Shared types and default latencies for the Execute-stage multi-cycle scheduler.
// Contents:
//   mc_state_t  - scheduler FSM states (IDLE, RUN, DONE)
//   mc_type_t   - multi-cycle op encoding as carried on McTypeE
//   LAT_MUL_DEF, LAT_DIV_DEF, CNT_W_DEF - default timing parameters
//   mc_is_div() - true for UDIV/SDIV
package arm_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mc_state_t;

  typedef enum logic [1:0] {
    MC_MUL  = 2'b00,
    MC_MULS = 2'b01,
    MC_UDIV = 2'b10,
    MC_SDIV = 2'b11
  } mc_type_t;

  localparam int unsigned LAT_MUL_DEF = 4;
  localparam int unsigned LAT_DIV_DEF = 12;
  localparam int unsigned CNT_W_DEF   = 4;

  function automatic logic mc_is_div(input mc_type_t t);
    return (t == MC_UDIV) || (t == MC_SDIV);
  endfunction

endpackage

// File: rtl/mc_lat_counter.sv
// Loadable down-counter that times the RUN phase of a multi-cycle op.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset (count -> 0)
//   load, load_val    - load a new count (load has priority over en)
//   en                - decrement by one; holds at 0 instead of wrapping
//   zero              - count == 0
//   last              - count == 1 (the decrement in this cycle reaches 0)
module mc_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == CNT_W'(1));

endmodule

// File: rtl/mc_exec_sched.sv
// Execute-stage scheduler for the iterative multiply/divide unit.
// Starts the unit on a condition-passing multi-cycle op, stalls F/D/E for the op
// latency, and gates the Execute flag write so flags update only on completion.
// Optional build macro: MC_SCHED_PERF_EN adds mc_stall_cycles (saturating count of
// cycles with StallE high).
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   McOpE, McTypeE       - multi-cycle op present in Execute and its type
//   CondExE              - condition pass
//   FlagWriteE_in        - decoder flag-write request
//   DivZeroE             - divisor is zero
//   FlushE               - Execute flush from the hazard unit
//   mc_start, mc_abort   - one-cycle pulses to the multiply/divide unit
//   StallF/D/E           - pipeline stall requests
//   FlagWriteE_out       - gated flag write to the condition unit
//   McResultSelE         - select mc unit result onto the Execute result bus
//   McBusy               - high while in RUN
//   mc_stall_cycles      - (MC_SCHED_PERF_EN only) stall cycle counter
module mc_exec_sched
  import arm_mc_pkg::*;
#(
  parameter int unsigned LAT_MUL = LAT_MUL_DEF,
  parameter int unsigned LAT_DIV = LAT_DIV_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       McOpE,
  input  logic [1:0] McTypeE,
  input  logic       CondExE,
  input  logic [1:0] FlagWriteE_in,
  input  logic       DivZeroE,
  input  logic       FlushE,
  output logic       mc_start,
  output logic       mc_abort,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic [1:0] FlagWriteE_out,
  output logic       McResultSelE,
  output logic       McBusy
`ifdef MC_SCHED_PERF_EN
  ,
  output logic [15:0] mc_stall_cycles
`endif
);

  // The counter holds the number of RUN cycles still to go, so loading LAT-2 gives
  // one start cycle + (LAT-2) RUN cycles + one DONE cycle = LAT cycles total.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(LAT_MUL - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(LAT_DIV - 2);

  mc_state_t        state_q, state_d;
  mc_type_t         mc_type;
  logic             go;
  logic             is_div;
  logic [CNT_W-1:0] load_val;
  logic             cnt_load, cnt_en, cnt_zero, cnt_last;

  logic       start_c, abort_c, stall_c, rsel_c, busy_c;
  logic [1:0] fw_c;

  mc_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (load_val),
    .en       (cnt_en),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_comb begin
    mc_type  = mc_type_t'(McTypeE);
    is_div   = mc_is_div(mc_type);
    load_val = is_div ? DIV_LOAD : MUL_LOAD;
    go       = McOpE & CondExE & ~FlushE;

    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    start_c  = 1'b0;
    abort_c  = 1'b0;
    stall_c  = 1'b0;
    rsel_c   = 1'b0;
    busy_c   = 1'b0;
    fw_c     = 2'b00;

    unique case (state_q)
      IDLE: begin
        // Ordinary instructions pass their flag write through; any multi-cycle op
        // (skipped or starting) writes no flags here.
        fw_c = McOpE ? 2'b00 : FlagWriteE_in;
        if (go) begin
          stall_c = 1'b1;
          if (is_div && DivZeroE) begin
            // Result comes from the unit's zero path; the unit is never started.
            state_d = DONE;
          end else begin
            start_c  = 1'b1;
            cnt_load = 1'b1;
            // A 2-cycle latency has no RUN phase at all.
            state_d  = (load_val == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        if (FlushE) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_last || cnt_zero) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // McOpE is deliberately ignored: a following op starts next cycle at earliest.
        rsel_c  = 1'b1;
        fw_c    = (mc_type == MC_MULS) ? FlagWriteE_in : 2'b00;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low while reset is held, independent of the live inputs.
  always_comb begin
    mc_start       = start_c & ~reset;
    mc_abort       = abort_c & ~reset;
    StallF         = stall_c & ~reset;
    StallD         = stall_c & ~reset;
    StallE         = stall_c & ~reset;
    FlagWriteE_out = reset ? 2'b00 : fw_c;
    McResultSelE   = rsel_c & ~reset;
    McBusy         = busy_c & ~reset;
  end

`ifdef MC_SCHED_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= 16'h0000;
    end else if (StallE && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign mc_stall_cycles = perf_q;
`endif

endmodule
